// File: rtl/mem_read_master.sv
// mem_read_master: read requester for a byte-wide memory.
// Takes {addr, len} requests, walks the memory one beat at a time with a
// fresh enable edge per beat, samples data RD_LAT cycles after enable and
// queues {data, last} in a small response FIFO.
// Optional feature macro: MEM_READ_MASTER_BURST_EN (multi-beat bursts).
// Without it every request is a single beat and req_len is ignored.
module mem_read_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              mem_read,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = 2;

  // lat_reg counts sample edges already passed since enable rose; the
  // edge that makes it reach RD_LAT is the capture edge, so compare
  // against RD_LAT-1 to sample exactly RD_LAT edges after enable.
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [LEN_W:0]    REM_ONE  = (LEN_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [LEN_W:0]      rem_reg, rem_next;
  logic [LAT_W-1:0]    lat_reg, lat_next;
  logic                en_reg, en_next;

  logic [DATA_W-1:0]   data_mem [FIFO_DEPTH];
  logic                last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic                pop;
  logic                capture;
  logic                last_beat;

`ifndef MEM_READ_MASTER_BURST_EN
  logic unused_len;
  assign unused_len = ^req_len;
`endif

  assign req_ready  = (state_reg == IDLE);
  assign mem_read   = en_reg;
  assign mem_enable = en_reg;
  assign mem_addr   = addr_reg;

  assign rsp_valid  = (cnt_reg != '0);
  assign rsp_data   = rsp_valid ? data_mem[rd_ptr_reg] : '0;
  assign rsp_last   = rsp_valid ? last_mem[rd_ptr_reg] : 1'b0;

  assign pop        = rsp_valid && rsp_ready;
  assign last_beat  = (rem_reg == REM_ONE);
  // A full FIFO still accepts a beat when the head leaves on the same edge.
  assign capture    = (state_reg == ACCESS) && (lat_reg == LAT_LAST) &&
                      ((cnt_reg < CNT_FULL) || pop);

  // Next-state and memory-control decode for the IDLE/ACCESS/GAP walker.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    lat_next   = lat_reg;
    en_next    = en_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          addr_next  = req_addr;
`ifdef MEM_READ_MASTER_BURST_EN
          rem_next   = {1'b0, req_len} + REM_ONE;
`else
          rem_next   = REM_ONE;
`endif
          lat_next   = '0;
          en_next    = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (capture) begin
          en_next = 1'b0;
          if (last_beat) begin
            state_next = IDLE;
          end else begin
            rem_next   = rem_reg - REM_ONE;
            addr_next  = addr_reg + ADDR_ONE;
            state_next = GAP;
          end
        end else if (lat_reg != LAT_LAST) begin
          lat_next = lat_reg + LAT_ONE;
        end
      end
      GAP: begin
        lat_next   = '0;
        en_next    = 1'b1;
        state_next = ACCESS;
      end
      default: begin
        en_next    = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Walker state registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      rem_reg   <= '0;
      lat_reg   <= '0;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rem_reg   <= rem_next;
      lat_reg   <= lat_next;
      en_reg    <= en_next;
    end
  end

  // Response FIFO storage; contents are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (capture) begin
      data_mem[wr_ptr_reg] <= mem_data;
      last_mem[wr_ptr_reg] <= last_beat;
    end
  end

  // Response FIFO pointers and occupancy; reset flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (capture) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({capture, pop})
        2'b10:   cnt_reg <= cnt_reg + CNT_ONE;
        2'b01:   cnt_reg <= cnt_reg - CNT_ONE;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule
